// File: rtl/cordic_sweep_gen_if.sv
// Sweep generator bundle: config request, abort, theta stream to the CORDIC, and status.
// Latency: n/a (wires only).
// Backpressure: theta_valid/theta_ready handshake; cfg_valid/cfg_ready handshake.
// Ports (slave = generator side):
//   cfg_valid/cfg_ready, start_phase, phase_step, sample_count, repeat_mode -- sweep request
//   abort -- terminate active sweep
//   theta/theta_valid/theta_ready -- phase word stream to the CORDIC
//   busy, done, sent_count -- status
interface cordic_sweep_gen_if #(
  parameter int WIDTH = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] start_phase;
  logic [WIDTH-1:0] phase_step;
  logic [WIDTH-1:0] sample_count;
  logic             repeat_mode;
  logic             abort;
  logic [WIDTH-1:0] theta;
  logic             theta_valid;
  logic             theta_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sent_count;

  modport slave (
    input  cfg_valid, start_phase, phase_step, sample_count, repeat_mode, abort, theta_ready,
    output cfg_ready, theta, theta_valid, busy, done, sent_count
  );

  modport master (
    output cfg_valid, start_phase, phase_step, sample_count, repeat_mode, abort, theta_ready,
    input  cfg_ready, theta, theta_valid, busy, done, sent_count
  );
endinterface

// File: rtl/cordic_sweep_gen.sv
// Phase sweep generator: emits sample_count theta words start_phase + k*phase_step to a CORDIC.
// Latency: first theta valid 1 cycle after cfg accept; one word per cycle while theta_ready is high.
// Backpressure: theta/theta_valid hold while theta_ready is low; cfg_ready only in IDLE.
// Ports: i_clk (clock), i_rst (synchronous active-high reset), s_if (cordic_sweep_gen_if.slave).
// Optional feature: define CORDIC_SWEEP_REPEAT_EN to enable continuous (repeat_mode) sweeps.
// Only WIDTH=16 is supported.
module cordic_sweep_gen #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  cordic_sweep_gen_if.slave s_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_theta;
  logic [WIDTH-1:0] r_sent;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] r_count;

  logic             w_accept;
  logic             w_xfer;
  logic             w_last;
  logic             w_wrap;

`ifdef CORDIC_SWEEP_REPEAT_EN
  logic             r_repeat;
`else
  // repeat_mode is deliberately ignored in this build
  logic             w_unused_repeat;
  assign w_unused_repeat = s_if.repeat_mode;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    w_xfer           = 1'b0;
    w_last           = 1'b0;
    w_wrap           = 1'b0;
    s_if.cfg_ready   = 1'b0;
    s_if.theta_valid = 1'b0;
    s_if.busy        = 1'b0;
    s_if.done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_if.cfg_ready = 1'b1;
        if (s_if.cfg_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (s_if.sample_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        s_if.theta_valid = 1'b1;
        s_if.busy        = 1'b1;
        w_xfer           = s_if.theta_ready;
        // sent_count wraps mod 2^16, so compare the wrapped increment
        w_last           = w_xfer && (WIDTH'(r_sent + 1'b1) == r_count);
`ifdef CORDIC_SWEEP_REPEAT_EN
        w_wrap           = w_last && r_repeat;
`endif
        // abort wins over completion: no DONE, no done pulse
        if (s_if.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last && !w_wrap) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        s_if.busy   = 1'b1;
        s_if.done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: a transfer in an abort cycle still advances theta and sent_count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_theta  <= '0;
      r_sent   <= '0;
      r_start  <= '0;
      r_step   <= '0;
      r_count  <= '0;
`ifdef CORDIC_SWEEP_REPEAT_EN
      r_repeat <= 1'b0;
`endif
    end else if (w_accept) begin
      r_theta  <= s_if.start_phase;
      r_sent   <= '0;
      r_start  <= s_if.start_phase;
      r_step   <= s_if.phase_step;
      r_count  <= s_if.sample_count;
`ifdef CORDIC_SWEEP_REPEAT_EN
      r_repeat <= s_if.repeat_mode;
`endif
    end else if (w_xfer) begin
      if (w_wrap) begin
        r_theta <= r_start;
        r_sent  <= '0;
      end else begin
        r_theta <= r_theta + r_step;
        r_sent  <= r_sent + 1'b1;
      end
    end
  end

  assign s_if.theta      = r_theta;
  assign s_if.sent_count = r_sent;

endmodule

// File: tb/tb_cordic_sweep_gen.sv
// Testbench for cordic_sweep_gen: directed and randomized sweeps against a closed-form model.
// Latency: n/a.
// Backpressure: theta_ready driven from fixed patterns or random stall percentages.
module tb_cordic_sweep_gen;

  logic clk = 1'b0;
  logic rst;

  cordic_sweep_gen_if #(.WIDTH(16)) sif ();

  cordic_sweep_gen #(.WIDTH(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_if  (sif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    sif.cfg_valid    = 1'b0;
    sif.start_phase  = 16'h0;
    sif.phase_step   = 16'h0;
    sif.sample_count = 16'h0;
    sif.repeat_mode  = 1'b0;
    sif.abort        = 1'b0;
    sif.theta_ready  = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] exp_sent);
    chk({tag, "_cfg_ready"}, 16'(sif.cfg_ready), 16'd1);
    chk({tag, "_busy"}, 16'(sif.busy), 16'd0);
    chk({tag, "_done"}, 16'(sif.done), 16'd0);
    chk({tag, "_valid"}, 16'(sif.theta_valid), 16'd0);
    chk({tag, "_sent"}, sif.sent_count, exp_sent);
  endtask

  // One sweep. stall_pct < 0 selects the ready pattern 1,0,0,1,0,1.
  // abort_at > 0 asserts abort together with that transfer number.
  task automatic sweep(input string tag, input logic [15:0] st, input logic [15:0] step,
                       input logic [15:0] cnt, input int stall_pct, input int abort_at);
    bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int   sent = 0;
    int   cyc  = 0;
    bit   rdy;
    bit   ab;
    logic [15:0] exp_th;

    chk({tag, "_pre_cfg_ready"}, 16'(sif.cfg_ready), 16'd1);
    sif.cfg_valid    = 1'b1;
    sif.start_phase  = st;
    sif.phase_step   = step;
    sif.sample_count = cnt;
`ifdef CORDIC_SWEEP_REPEAT_EN
    sif.repeat_mode  = 1'b0;
`else
    sif.repeat_mode  = 1'($urandom);
`endif
    @(negedge clk);

    if (cnt == 16'd0) begin
      idle_inputs();
      chk({tag, "_z_valid"}, 16'(sif.theta_valid), 16'd0);
      chk({tag, "_z_done"}, 16'(sif.done), 16'd1);
      chk({tag, "_z_busy"}, 16'(sif.busy), 16'd1);
      chk({tag, "_z_sent"}, sif.sent_count, 16'd0);
      @(negedge clk);
      chk_idle({tag, "_z_after"}, 16'd0);
      return;
    end

    while (cyc < 2000) begin
      exp_th = 16'(32'(st) + 32'(sent) * 32'(step));
      chk({tag, "_valid"}, 16'(sif.theta_valid), 16'd1);
      chk({tag, "_theta"}, sif.theta, exp_th);
      chk({tag, "_done_low"}, 16'(sif.done), 16'd0);
      chk({tag, "_busy"}, 16'(sif.busy), 16'd1);
      chk({tag, "_sent"}, sif.sent_count, 16'(sent));

      rdy = (stall_pct < 0) ? pat[cyc % 6] : (int'($urandom_range(0, 99)) >= stall_pct);
      ab  = (abort_at > 0) && rdy && (sent + 1 == abort_at);
      sif.theta_ready  = rdy;
      sif.abort        = ab;
      // Garbage config while running must be ignored
      sif.cfg_valid    = 1'($urandom);
      sif.start_phase  = 16'($urandom);
      sif.phase_step   = 16'($urandom);
      sif.sample_count = 16'($urandom);
      @(negedge clk);
      if (rdy) sent++;

      if (ab) begin
        idle_inputs();
        chk_idle({tag, "_abort"}, 16'(sent));
        return;
      end
      if (sent == int'(cnt)) begin
        idle_inputs();
        chk({tag, "_end_valid"}, 16'(sif.theta_valid), 16'd0);
        chk({tag, "_end_done"}, 16'(sif.done), 16'd1);
        chk({tag, "_end_busy"}, 16'(sif.busy), 16'd1);
        chk({tag, "_end_sent"}, sif.sent_count, cnt);
        @(negedge clk);
        chk_idle({tag, "_after"}, cnt);
        return;
      end
      cyc++;
    end
    chk({tag, "_timeout"}, 16'(sent), cnt);
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_theta", sif.theta, 16'h0);
    chk_idle("rst", 16'h0);
    rst = 1'b0;
    @(negedge clk);

    sweep("quad",  16'h0000, 16'h4000, 16'd4, 0, 0);
    sweep("wrap",  16'hF000, 16'h2000, 16'd2, 0, 0);
    sweep("stall", 16'h1234, 16'h0111, 16'd3, -1, 0);
    sweep("zero",  16'h5555, 16'h0001, 16'd0, 0, 0);
    sweep("step0", 16'hABCD, 16'h0000, 16'd5, 30, 0);
    sweep("abort", 16'h0010, 16'h0020, 16'd10, 0, 2);

    // abort in IDLE is ignored and sent_count holds
    sif.abort = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0;
    @(negedge clk);
    chk_idle("idle_abort", 16'd2);

    for (int i = 0; i < 10; i++) begin
      sweep("rand", 16'($urandom), 16'($urandom), 16'($urandom_range(1, 20)),
            int'($urandom_range(0, 60)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      @(negedge clk);
    end

    // Reset mid-sweep beats abort, cfg and handshake
    sif.cfg_valid    = 1'b1;
    sif.start_phase  = 16'h0300;
    sif.phase_step   = 16'h0010;
    sif.sample_count = 16'd10;
    @(negedge clk);
    sif.cfg_valid   = 1'b0;
    sif.theta_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_theta", sif.theta, 16'h0330);
    rst             = 1'b1;
    sif.abort       = 1'b1;
    sif.cfg_valid   = 1'b1;
    @(negedge clk);
    chk("mid_rst_theta", sif.theta, 16'h0);
    chk_idle("mid_rst", 16'h0);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk_idle("post_rst", 16'h0);

`ifdef CORDIC_SWEEP_REPEAT_EN
    sif.cfg_valid    = 1'b1;
    sif.start_phase  = 16'h0100;
    sif.phase_step   = 16'h0100;
    sif.sample_count = 16'd2;
    sif.repeat_mode  = 1'b1;
    @(negedge clk);
    sif.cfg_valid   = 1'b0;
    sif.theta_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk("rep_valid", 16'(sif.theta_valid), 16'd1);
      chk("rep_theta", sif.theta, (k % 2 == 0) ? 16'h0100 : 16'h0200);
      chk("rep_done", 16'(sif.done), 16'd0);
      @(negedge clk);
    end
    sif.abort = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("rep_abort_valid", 16'(sif.theta_valid), 16'd0);
    chk("rep_abort_done", 16'(sif.done), 16'd0);
    chk("rep_abort_busy", 16'(sif.busy), 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
